latch_sampler: RTL and testbench
================================

# latch_sampler

Digital back-end stage that sits directly downstream of the Mr_Latch CMOS latch/inverter cell. Takes the cell's raw, asynchronous output, synchronises and debounces it, counts settled rising and falling transitions, and serialises a snapshot of those counts on request. The serial snapshot goes out over a dedicated output pin for off-chip characterisation of the latch.

## Interface
Parameters:
- DEBOUNCE, 4, consecutive stable cycles required before `q_filt` accepts a new level; legal range 1..255.
- CNT_W, 8, width of each transition counter; frame width F = 2*CNT_W+1.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  active-high asynchronous reset.
- latch_q  in  1  raw latch output; asynchronous to `clk`.
- en  in  1  count enable; when low, counters hold, filter still runs.
- snap  in  1  capture request; sampled only in IDLE.
- shift_en  in  1  advance the serial frame by one bit.
- q_filt  out  1  synchronised, debounced latch level.
- rise_pulse  out  1  one-cycle pulse on each accepted 0->1 of `q_filt`.
- fall_pulse  out  1  one-cycle pulse on each accepted 1->0 of `q_filt`.
- shift_out  out  1  current frame bit, MSB first.
- busy  out  1  high while a frame is being shifted.
- done  out  1  one-cycle pulse after the last frame bit is consumed.

## Operation
- Reset values: sync1=sync2=0, q_filt=0, stable counter=0, rise_cnt=fall_cnt=0, ovf=0, rise_pulse=fall_pulse=0, shift_out=0, busy=0, done=0, state=IDLE. Reset is asynchronous and abandons any frame in progress.
- Synchroniser: two flops, latch_q -> sync1 -> sync2. No logic between them.
- Debounce, evaluated every edge:
  - If sync2 != q_filt and cnt == DEBOUNCE-1: q_filt <= sync2, cnt <= 0, and the matching rise/fall pulse is 1 on that same edge.
  - Else if sync2 != q_filt: cnt++.
  - Else: cnt <= 0. Any glitch shorter than DEBOUNCE cycles at sync2 is discarded.
- Counters:
  - Each pulse increments rise_cnt or fall_cnt when en=1.
  - A counter at all-ones saturates and sets sticky ovf.
- Frame layout, MSB first: {ovf, rise_cnt[CNT_W-1:0], fall_cnt[CNT_W-1:0]}.
- FSM:
  - IDLE: snap=1 -> SHIFT. On that edge the frame is loaded and rise_cnt, fall_cnt and ovf are cleared (read-and-clear). A pulse with en=1 on the load edge is counted into the new window, so the counter becomes 1 and is not included in the loaded frame.
  - SHIFT: busy=1 and shift_out = frame MSB. Each edge with shift_en=1 shifts left by one and increments the bit index. shift_en=0 stalls with shift_out held. The edge that consumes bit index F-1 -> DONE.
  - DONE: busy=0, done=1, shift_out=0; next edge -> IDLE unconditionally.
- snap in SHIFT or DONE is ignored; it is not queued.

## Timing
- Filter latency: with latch_q changing before edge k, q_filt and the pulse appear after edge k+1+DEBOUNCE, i.e. DEBOUNCE+2 edges including k. With DEBOUNCE=4 that is 6 edges.
- Counter value reflects a pulse one cycle after the pulse edge.
- snap at edge j: busy=1 and shift_out=ovf after edge j. With shift_en held high, bit i is presented after edge j+i, done=1 after edge j+F, and busy=0 from that same edge.
- Minimum snap-to-snap interval is F+2 cycles, 19 for the defaults.
- All outputs are registered; no combinational path from input to output.

## Test plan
- Reset: assert rst mid-frame, asynchronously between edges. All outputs go to 0 immediately; after release, a snap frame is all zeros (17 bits).
- Debounce: DEBOUNCE=4, latch_q 0->1 held. q_filt=1 and rise_pulse=1 on the 6th edge. A separate 3-cycle high glitch produces no q_filt change and no pulse.
- Counting plus snap: 5 clean rises and 4 falls with en=1, then snap with shift_en=1. shift_out sequence is 0, 00000101, 00000100. done pulses after edge 17; counters then read 0.
- Saturation: CNT_W=4, 20 rises. The frame is 1, 1111, then fall_cnt. The next frame shows ovf=0.
- Stall and ignored snap: toggle shift_en 1/0 during a frame. Bits repeat while stalled, and a snap during SHIFT does not restart the frame.
- Simultaneous event: a rise accepted on the snap edge is excluded from the frame, and the next frame's rise_cnt=1.

Source files
------------

// File: rtl/latch_sampler.sv
// Back-end for the Mr_Latch cell: synchronise and debounce the raw latch output,
// count settled edges, and serialise a read-and-clear snapshot of the counts.
module latch_sampler #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic latch_q,
    input  logic en,
    input  logic snap,
    input  logic shift_en,
    output logic q_filt,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic shift_out,
    output logic busy,
    output logic done
);
    localparam int F  = 2 * CNT_W + 1;
    localparam int IW = $clog2(F);
    localparam logic [7:0]    DB_LAST  = 8'(DEBOUNCE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(F - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic             sync1, sync2;
    logic [7:0]       db_cnt;
    logic [CNT_W-1:0] rise_cnt, fall_cnt;
    logic             ovf;
    logic [F-1:0]     frame;
    logic [IW-1:0]    idx;
    logic             load, shift;
    logic             rise_inc, fall_inc;

    // Plain two-flop synchroniser followed by the debounce filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            q_filt     <= 1'b0;
            db_cnt     <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync1      <= latch_q;
            sync2      <= sync1;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (sync2 != q_filt && db_cnt == DB_LAST) begin
                q_filt     <= sync2;
                db_cnt     <= '0;
                rise_pulse <= sync2;
                fall_pulse <= ~sync2;
            end else if (sync2 != q_filt) begin
                db_cnt <= db_cnt + 8'd1;
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign rise_inc = rise_pulse & en;
    assign fall_inc = fall_pulse & en;

    // On the load edge the old counts go into the frame; a coincident pulse
    // starts the new window at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
            ovf      <= 1'b0;
        end else if (load) begin
            rise_cnt <= CNT_W'(rise_inc);
            fall_cnt <= CNT_W'(fall_inc);
            ovf      <= 1'b0;
        end else begin
            if (rise_inc) begin
                if (&rise_cnt) ovf <= 1'b1;
                else           rise_cnt <= rise_cnt + CNT_W'(1);
            end
            if (fall_inc) begin
                if (&fall_cnt) ovf <= 1'b1;
                else           fall_cnt <= fall_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift    = 1'b0;
        case (state)
            IDLE: if (snap) begin
                state_nx = SHIFT;
                load     = 1'b1;
            end
            SHIFT: if (shift_en) begin
                shift = 1'b1;
                if (idx == IDX_LAST) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Zero fill means the frame MSB is already 0 in DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            frame <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == SHIFT);
            done  <= (state_nx == DONE);
            if (load) begin
                frame <= {ovf, rise_cnt, fall_cnt};
                idx   <= '0;
            end else if (shift) begin
                frame <= {frame[F-2:0], 1'b0};
                idx   <= idx + IW'(1);
            end
        end
    end

    assign shift_out = frame[F-1];
endmodule

// File: tb/tb_latch_sampler.sv
// Directed bench for latch_sampler: default instance plus a narrow-counter,
// fast-debounce instance for saturation.
module tb_latch_sampler;
    logic clk = 1'b0;
    logic rst;
    logic latch_q0, en0, snap0, shift_en0;
    logic q_filt0, rise_pulse0, fall_pulse0, shift_out0, busy0, done0;
    logic latch_q1, en1, snap1, shift_en1;
    logic q_filt1, rise_pulse1, fall_pulse1, shift_out1, busy1, done1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    latch_sampler #(.DEBOUNCE(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .latch_q(latch_q0), .en(en0), .snap(snap0),
        .shift_en(shift_en0), .q_filt(q_filt0), .rise_pulse(rise_pulse0),
        .fall_pulse(fall_pulse0), .shift_out(shift_out0), .busy(busy0), .done(done0)
    );

    latch_sampler #(.DEBOUNCE(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .latch_q(latch_q1), .en(en1), .snap(snap1),
        .shift_en(shift_en1), .q_filt(q_filt1), .rise_pulse(rise_pulse1),
        .fall_pulse(fall_pulse1), .shift_out(shift_out1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic level0(input logic b, input int n);
        latch_q0 = b;
        repeat (n) tick();
    endtask

    task automatic level1(input logic b, input int n);
        latch_q1 = b;
        repeat (n) tick();
    endtask

    task automatic grab0(input string tag, input logic [16:0] exp);
        logic [16:0] f;
        f = '0;
        snap0 = 1'b1; shift_en0 = 1'b1;
        tick();
        snap0 = 1'b0;
        chk({tag, "_busy"}, busy0, 1);
        for (int i = 0; i < 17; i++) begin
            f[16-i] = shift_out0;
            tick();
        end
        chk({tag, "_frame"}, f, exp);
        chk({tag, "_done"}, {done0, busy0, shift_out0}, 3'b100);
        shift_en0 = 1'b0;
        tick();
        chk({tag, "_done_clr"}, done0, 0);
    endtask

    task automatic grab1(input string tag, input logic [8:0] exp);
        logic [8:0] f;
        f = '0;
        snap1 = 1'b1; shift_en1 = 1'b1;
        tick();
        snap1 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            f[8-i] = shift_out1;
            tick();
        end
        chk({tag, "_frame"}, f, exp);
        chk({tag, "_done"}, {done1, busy1}, 2'b10);
        shift_en1 = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [16:0] exp;
        logic        seen;
        rst = 1'b1;
        latch_q0 = 0; en0 = 0; snap0 = 0; shift_en0 = 0;
        latch_q1 = 0; en1 = 0; snap1 = 0; shift_en1 = 0;
        tick(); tick();
        chk("reset_outs0", {q_filt0, rise_pulse0, fall_pulse0, shift_out0, busy0, done0}, 6'b0);
        chk("reset_outs1", {q_filt1, rise_pulse1, fall_pulse1, shift_out1, busy1, done1}, 6'b0);
        rst = 1'b0;
        tick();

        // debounce latency: change lands on the 6th edge
        level0(1'b1, 5);
        chk("db_q_before", {q_filt0, rise_pulse0}, 2'b00);
        tick();
        chk("db_q_6th", {q_filt0, rise_pulse0}, 2'b11);
        tick();
        chk("db_pulse_1cyc", {q_filt0, rise_pulse0}, 2'b10);
        level0(1'b0, 6);
        chk("db_fall", {q_filt0, fall_pulse0}, 2'b01);
        tick();
        // 3-cycle glitch must be filtered
        level0(1'b1, 3);
        latch_q0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (q_filt0 || rise_pulse0) seen = 1'b1;
            tick();
        end
        chk("glitch_filtered", seen, 0);
        // en was low throughout: counters held at zero
        grab0("en_hold", 17'h0);

        // 5 rises and 4 falls
        en0 = 1'b1;
        for (int i = 0; i < 9; i++) level0(i[0] ? 1'b0 : 1'b1, 8);
        grab0("count", 17'h00504);
        grab0("count_clr", 17'h0);

        // stall and ignored snap: 2 rises, 2 falls
        level0(1'b0, 8); level0(1'b1, 8); level0(1'b0, 8); level0(1'b1, 8);
        exp = 17'h00202;
        snap0 = 1'b1; shift_en0 = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) begin
            chk("stall_pre", shift_out0, exp[16-i]);
            tick();
            chk("stall_hold", {busy0, shift_out0}, {1'b1, exp[16-i]});
            shift_en0 = 1'b1;
            tick();
            shift_en0 = 1'b0;
        end
        chk("stall_done", {done0, busy0}, 2'b10);
        snap0 = 1'b0;
        tick();
        chk("stall_idle", {done0, busy0}, 2'b00);

        // rise pulse coincident with the load edge
        level0(1'b0, 8);
        level0(1'b1, 5);
        chk("sim_pre", rise_pulse0, 0);
        tick();
        chk("sim_pulse", rise_pulse0, 1);
        grab0("sim_excl", 17'h00001);
        grab0("sim_next", 17'h00100);

        // saturation with CNT_W=4
        en1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            level1(1'b1, 4);
            level1(1'b0, 4);
        end
        grab1("sat", 9'h1FF);
        grab1("sat_clr", 9'h000);
        en1 = 1'b0;
        level1(1'b1, 4);
        chk("sat_q1", q_filt1, 1);
        level1(1'b0, 4);
        grab1("en1_hold", 9'h000);

        // asynchronous reset mid-frame
        level0(1'b0, 8);
        level0(1'b1, 8);
        latch_q0 = 1'b0;
        snap0 = 1'b1; shift_en0 = 1'b1;
        tick();
        snap0 = 1'b0;
        tick(); tick();
        #3 rst = 1'b1;
        #1;
        chk("arst_outs", {q_filt0, rise_pulse0, fall_pulse0, shift_out0, busy0, done0}, 6'b0);
        #2 rst = 1'b0;
        shift_en0 = 1'b0;
        repeat (8) tick();
        grab0("arst_frame", 17'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
